pam_approx_mult_pipe: RTL and testbench

Parametrised, pipelined unsigned approximate multiplier with a per-transaction exact/approximate mode and a valid/ready stream interface. In approximate mode it removes all partial-product bits below a configurable column and adds a fixed compensation constant. It is the successor to the fixed 8x8 combinational truncated multipliers and is intended for error-tolerant datapaths that need back-pressure and a registered output.

---
 rtl/pam_mult_pkg.sv | 54 +++++
 rtl/pam_pp_reduce.sv | 44 ++++
 rtl/pam_approx_mult_pipe.sv | 116 +++++++++++
 tb/tb_pam_approx_mult_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pam_mult_pkg.sv
// Shared constants and reference helpers for the pipelined approximate multiplier.
// The column-mask function is used by the RTL; the reference product is used by the bench.
package pam_mult_pkg;

   localparam int MAX_W  = 16;
   localparam int MAX_PW = 2 * MAX_W;

   localparam logic MODE_EXACT  = 1'b0;
   localparam logic MODE_APPROX = 1'b1;

   typedef struct packed {
      logic [MAX_PW-1:0] z;
      logic              sat;
   } ref_res_t;

   // Bit k set when product column k survives truncation (k >= trunc, k < 2w).
   function automatic logic [MAX_PW:0] col_mask(input int w, input int trunc);
      logic [MAX_PW:0] m;
      m = '0;
      for (int k = 0; k < 2 * w; k++) begin
         if (k >= trunc) m[k] = 1'b1;
      end
      return m;
   endfunction

   function automatic ref_res_t approx_ref(input int w, input int trunc,
                                           input logic [MAX_PW-1:0] comp,
                                           input logic [MAX_W-1:0] x,
                                           input logic [MAX_W-1:0] y,
                                           input logic mode);
      logic [MAX_PW+1:0] acc;
      logic [MAX_PW+1:0] max_v;
      ref_res_t          r;
      r = '0;
      if (x == '0 || y == '0) return r;
      acc = '0;
      for (int i = 0; i < w; i++) begin
         for (int j = 0; j < w; j++) begin
            if (x[i] && y[j] && (mode == MODE_EXACT || i + j >= trunc))
               acc = acc + ((MAX_PW+2)'(1) << (i + j));
         end
      end
      if (mode == MODE_APPROX && trunc != 0) acc = acc + {2'b00, comp};
      max_v = ((MAX_PW+2)'(1) << (2 * w)) - 1'b1;
      if (acc > max_v) begin
         r.z   = max_v[MAX_PW-1:0];
         r.sat = 1'b1;
      end else begin
         r.z = acc[MAX_PW-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/pam_pp_reduce.sv
// Masked partial-product generator with a 3:2 carry-save reduction to a sum/carry pair.
// Exact mode uses every column; approximate mode drops columns below TRUNC.
module pam_pp_reduce
   import pam_mult_pkg::*;
#(
   parameter int W     = 8,
   parameter int TRUNC = 7
) (
   input  logic [W-1:0]   i_x,
   input  logic [W-1:0]   i_y,
   input  logic           i_approx,
   output logic [2*W:0]   o_sum,
   output logic [2*W:0]   o_carry
);

   localparam int PW1 = 2 * W + 1;
   localparam logic [PW1-1:0] MASK = PW1'(col_mask(W, TRUNC));

   logic [PW1-1:0] w_mask;
   logic [PW1-1:0] w_pp;
   logic [PW1-1:0] w_s;
   logic [PW1-1:0] w_c;
   logic [PW1-1:0] w_ns;

   assign w_mask = (i_approx == MODE_APPROX) ? MASK : '1;

   // NOTE: every variable gets a default before the loop so no latch is inferred.
   always_comb begin
      w_pp = '0;
      w_s  = '0;
      w_c  = '0;
      w_ns = '0;
      for (int r = 0; r < W; r++) begin
         w_pp = ({{(W+1){1'b0}}, i_x & {W{i_y[r]}}} << r) & w_mask;
         w_ns = w_s ^ w_c ^ w_pp;
         w_c  = ((w_s & w_c) | (w_s & w_pp) | (w_c & w_pp)) << 1;
         w_s  = w_ns;
      end
   end

   assign o_sum   = w_s;
   assign o_carry = w_c;

endmodule

// File: rtl/pam_approx_mult_pipe.sv
// Three-stage valid/ready unsigned multiplier with per-beat exact/approximate mode,
// compensation, saturation, zero bypass and a delivered-result counter.
module pam_approx_mult_pipe
   import pam_mult_pkg::*;
#(
   parameter int W     = 8,
   parameter int TRUNC = 7,
   parameter int COMP  = 64,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       x,
   input  logic [W-1:0]       y,
   input  logic               approx,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*W-1:0]     z,
   output logic [TAG_W-1:0]   out_tag,
   output logic               sat,
   output logic [CNT_W-1:0]   op_cnt
);

   localparam int PW = 2 * W;
   localparam logic [PW-1:0] COMP_V = PW'(COMP);

   logic               r_s1_valid, r_s2_valid, r_s3_valid;
   logic [W-1:0]       r_s1_x, r_s1_y;
   logic               r_s1_approx, r_s1_zero;
   logic [TAG_W-1:0]   r_s1_tag;
   logic [PW:0]        r_s2_sum, r_s2_carry;
   logic               r_s2_approx, r_s2_zero;
   logic [TAG_W-1:0]   r_s2_tag;
   logic [PW-1:0]      r_z;
   logic [TAG_W-1:0]   r_tag;
   logic               r_sat;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_s1_en, w_s2_en, w_s3_en;
   logic [PW:0]        w_sum, w_carry, w_prod;
   logic [PW+1:0]      w_total;
   logic               w_comp_en, w_clamp, w_sat;
   logic [PW-1:0]      w_z;

   // Enables ripple back combinationally from out_ready: a stage loads when empty or draining.
   assign w_s3_en  = !r_s3_valid || out_ready;
   assign w_s2_en  = !r_s2_valid || w_s3_en;
   assign w_s1_en  = !r_s1_valid || w_s2_en;
   assign in_ready = w_s1_en;

   pam_pp_reduce #(.W(W), .TRUNC(TRUNC)) u_pp_reduce (
      .i_x      (r_s1_x),
      .i_y      (r_s1_y),
      .i_approx (r_s1_approx),
      .o_sum    (w_sum),
      .o_carry  (w_carry)
   );

   assign w_prod    = r_s2_sum + r_s2_carry;
   assign w_comp_en = (r_s2_approx == MODE_APPROX) && (TRUNC != 0);
   assign w_total   = {1'b0, w_prod} + (w_comp_en ? {2'b00, COMP_V} : '0);
   assign w_clamp   = |w_total[PW+1:PW];
   assign w_sat     = w_clamp && !r_s2_zero;
   assign w_z       = r_s2_zero ? '0 : (w_clamp ? '1 : w_total[PW-1:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s3_valid <= 1'b0;
         r_z        <= '0;
         r_tag      <= '0;
         r_sat      <= 1'b0;
         r_cnt      <= '0;
      end else begin
         if (w_s1_en) r_s1_valid <= in_valid;
         if (w_s2_en) r_s2_valid <= r_s1_valid;
         if (w_s3_en) r_s3_valid <= r_s2_valid;
         if (w_s3_en && r_s2_valid) begin
            r_z   <= w_z;
            r_tag <= r_s2_tag;
            r_sat <= w_sat;
         end
         if (r_s3_valid && out_ready) r_cnt <= r_cnt + 1'b1;
      end
   end

   // NOTE: inner stage payloads are qualified by their valid bits, so they carry no reset.
   always_ff @(posedge clk) begin
      if (w_s1_en && in_valid) begin
         r_s1_x      <= x;
         r_s1_y      <= y;
         r_s1_approx <= approx;
         r_s1_tag    <= in_tag;
         r_s1_zero   <= (x == '0) || (y == '0);
      end
      if (w_s2_en && r_s1_valid) begin
         r_s2_sum    <= w_sum;
         r_s2_carry  <= w_carry;
         r_s2_approx <= r_s1_approx;
         r_s2_tag    <= r_s1_tag;
         r_s2_zero   <= r_s1_zero;
      end
   end

   assign out_valid = r_s3_valid;
   assign z         = r_z;
   assign out_tag   = r_tag;
   assign sat       = r_sat;
   assign op_cnt    = r_cnt;

endmodule

// File: tb/tb_pam_approx_mult_pipe.sv
// Directed and randomised checks of pam_approx_mult_pipe, plus a COMP=2000 instance for saturation.
module tb_pam_approx_mult_pipe;
   import pam_mult_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid, in_ready, approx, out_valid, out_ready, sat;
   logic [7:0]  x, y;
   logic [3:0]  in_tag, out_tag;
   logic [15:0] z, op_cnt;

   logic        s_in_valid, s_in_ready, s_approx, s_out_valid, s_sat;
   logic [7:0]  s_x, s_y;
   logic [3:0]  s_in_tag, s_out_tag;
   logic [15:0] s_z, s_op_cnt;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [15:0] z;
      logic        sat;
      logic [3:0]  tag;
   } exp_t;

   exp_t q[$];

   pam_approx_mult_pipe #(.W(8), .TRUNC(7), .COMP(64), .TAG_W(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
      .approx(approx), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .z(z), .out_tag(out_tag), .sat(sat), .op_cnt(op_cnt)
   );

   pam_approx_mult_pipe #(.W(8), .TRUNC(7), .COMP(2000), .TAG_W(4), .CNT_W(16)) u_dut_sat (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .x(s_x), .y(s_y),
      .approx(s_approx), .in_tag(s_in_tag), .out_valid(s_out_valid), .out_ready(1'b1),
      .z(s_z), .out_tag(s_out_tag), .sat(s_sat), .op_cnt(s_op_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_single(input logic a, input logic [7:0] xv, input logic [7:0] yv,
                             input logic [3:0] tg, input logic [15:0] ez, input logic es,
                             input string name);
      int lat;
      approx = a; x = xv; y = yv; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         step();
         lat++;
      end
      check({name, "_lat"}, lat, 3);
      check({name, "_z"}, z, ez);
      check({name, "_sat"}, sat, es);
      check({name, "_tag"}, out_tag, tg);
      step();
   endtask

   task automatic push(input logic a, input logic [7:0] xv, input logic [7:0] yv, input logic [3:0] tg);
      approx = a; x = xv; y = yv; in_tag = tg; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic sat_single(input logic a, input logic [15:0] ez, input logic es, input string name);
      int lat;
      s_approx = a; s_x = 8'd255; s_y = 8'd255; s_in_tag = 4'd9; s_in_valid = 1'b1;
      step();
      s_in_valid = 1'b0;
      lat = 1;
      while (!s_out_valid && lat < 10) begin
         step();
         lat++;
      end
      check({name, "_lat"}, lat, 3);
      check({name, "_z"}, s_z, ez);
      check({name, "_sat"}, s_sat, es);
      step();
   endtask

   initial begin
      int       sent, recv, cyc;
      logic     in_fire, stall_prev, prev_sat;
      logic [15:0] prev_z;
      logic [3:0]  prev_tag;
      ref_res_t r;
      exp_t     e;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; approx = 1'b0;
      x = '0; y = '0; in_tag = '0;
      s_in_valid = 1'b0; s_approx = 1'b0; s_x = '0; s_y = '0; s_in_tag = '0;
      repeat (3) step();
      rst = 1'b0;

      check("rst_out_valid", out_valid, 0);
      check("rst_z", z, 0);
      check("rst_tag", out_tag, 0);
      check("rst_sat", sat, 0);
      check("rst_op_cnt", op_cnt, 0);
      check("rst_in_ready", in_ready, 1);

      // Hand-computed vectors: 65025 - 769 + 64 = 64320, 16384 + 64 = 16448, small products collapse to COMP.
      run_single(1'b1, 8'd255, 8'd255, 4'd1, 16'd64320, 1'b0, "ap_255x255");
      run_single(1'b0, 8'd255, 8'd255, 4'd2, 16'd65025, 1'b0, "ex_255x255");
      run_single(1'b1, 8'd3,   8'd5,   4'd3, 16'd64,    1'b0, "ap_3x5");
      run_single(1'b1, 8'd0,   8'd200, 4'd4, 16'd0,     1'b0, "ap_0x200");
      run_single(1'b0, 8'd3,   8'd5,   4'd5, 16'd15,    1'b0, "ex_3x5");
      run_single(1'b1, 8'd128, 8'd128, 4'd6, 16'd16448, 1'b0, "ap_128x128");
      run_single(1'b0, 8'd0,   8'd0,   4'd7, 16'd0,     1'b0, "ex_0x0");
      run_single(1'b1, 8'd255, 8'd0,   4'd8, 16'd0,     1'b0, "ap_255x0");
      check("op_cnt_directed", op_cnt, 8);

      // Fill the pipe with out_ready low; a fourth beat is offered but must be refused.
      out_ready = 1'b0;
      push(1'b1, 8'd3,   8'd5,   4'd1);
      push(1'b0, 8'd12,  8'd13,  4'd2);
      push(1'b1, 8'd255, 8'd255, 4'd3);
      approx = 1'b0; x = 8'd9; y = 8'd9; in_tag = 4'd4; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("stall_in_ready", in_ready, 0);
         check("stall_hold", {out_valid, out_tag, z}, {1'b1, 4'd1, 16'd64});
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      check("drain0", {out_valid, out_tag, z}, {1'b1, 4'd1, 16'd64});
      step();
      check("drain1", {out_valid, out_tag, z}, {1'b1, 4'd2, 16'd156});
      step();
      check("drain2", {out_valid, out_tag, z}, {1'b1, 4'd3, 16'd64320});
      step();
      check("drain_empty", out_valid, 0);
      check("drain_in_ready", in_ready, 1);
      check("op_cnt_drain", op_cnt, 11);

      // One-cycle reset with three beats in flight.
      out_ready = 1'b0;
      push(1'b1, 8'd200, 8'd100, 4'd5);
      push(1'b0, 8'd17,  8'd19,  4'd6);
      push(1'b1, 8'd99,  8'd77,  4'd7);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_op_cnt", op_cnt, 0);
      check("midrst_in_ready", in_ready, 1);
      run_single(1'b0, 8'd7, 8'd9, 4'd8, 16'd63, 1'b0, "post_rst");
      check("post_rst_op_cnt", op_cnt, 1);

      // Random traffic with ~50% stalls on both sides, checked against the package model.
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0;
      in_fire = 1'b0; stall_prev = 1'b0;
      prev_z = '0; prev_tag = '0; prev_sat = 1'b0;
      sent = 0; recv = 0; cyc = 0;
      while (recv < 1000 && cyc < 20000) begin
         if (!in_valid || in_fire) begin
            if (sent < 1000 && $urandom_range(0, 1) == 1) begin
               x      = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
               y      = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
               approx = 1'($urandom_range(0, 1));
               in_tag = 4'(sent);
               in_valid = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (stall_prev)
            check("rand_hold", {out_valid, z, out_tag, sat}, {1'b1, prev_z, prev_tag, prev_sat});
         in_fire = in_valid && in_ready;
         if (in_fire) begin
            r = approx_ref(8, 7, 32'd64, {8'h00, x}, {8'h00, y}, approx);
            q.push_back({r.z[15:0], r.sat, in_tag});
            sent++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("rand_unexpected_beat", 1, 0);
            end else begin
               e = q.pop_front();
               check("rand_z", z, e.z);
               check("rand_sat", sat, e.sat);
               check("rand_tag", out_tag, e.tag);
            end
            recv++;
         end
         stall_prev = out_valid && !out_ready;
         prev_z = z; prev_tag = out_tag; prev_sat = sat;
         step();
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("rand_recv", recv, 1000);
      check("rand_queue_empty", q.size(), 0);
      check("rand_op_cnt", op_cnt, 1000);

      // COMP=2000: 64256 + 2000 exceeds 65535 and clamps.
      sat_single(1'b1, 16'd65535, 1'b1, "sat_ap");
      sat_single(1'b0, 16'd65025, 1'b0, "sat_ex");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
